// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared constants and helpers for the 32-point FFT pipeline.
//            FFT_N/FFT_IN_W/FFT_PTR_W size the input framer.
//            FFT_FRAME_W is the width of the flat frame bus (x0..x31).
//            bitrev5 returns the decimation-in-time input index.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N       = 32;
    localparam int FFT_IN_W    = 8;
    localparam int FFT_PTR_W   = 5;
    localparam int FFT_OUT_W   = 32;
    localparam int FFT_FRAME_W = FFT_N * FFT_IN_W;

    // Reverse the order of the five bits of a sample index.
    function automatic logic [FFT_PTR_W-1:0] bitrev5(input logic [FFT_PTR_W-1:0] k);
        logic [FFT_PTR_W-1:0] r;
        for (int b = 0; b < FFT_PTR_W; b++) begin
            r[b] = k[FFT_PTR_W-1-b];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_input_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_input_framer_if
// Purpose  : Groups the framer's sample and frame handshake signals.
//            Sample side : s_data, s_valid, s_ready, plus flush.
//            Frame side  : frame_data, frame_valid, frame_ready, frame_cnt.
// Modports : master - the environment, which drives samples and consumes
//                     frames.
//            slave  - the framer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_input_framer_if #(
    parameter int DATA_W = 8,
    parameter int N      = 32,
    parameter int CNT_W  = 16
);

    logic                flush;
    logic [DATA_W-1:0]   s_data;
    logic                s_valid;
    logic                s_ready;
    logic [N*DATA_W-1:0] frame_data;
    logic                frame_valid;
    logic                frame_ready;
    logic [CNT_W-1:0]    frame_cnt;

    modport master (
        output flush, s_data, s_valid, frame_ready,
        input  s_ready, frame_data, frame_valid, frame_cnt
    );

    modport slave (
        input  flush, s_data, s_valid, frame_ready,
        output s_ready, frame_data, frame_valid, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_bank
// Purpose  : Array of N x DATA_W registers holding one frame.
//            The array has one write port and a flat read bus.
// Ports    : clk, rst_n (async active-low).
//            we, addr, wdata form the write port.
//            rdata is the flat bus; slot i is at [i*DATA_W +: DATA_W].
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_bank #(
    parameter int DATA_W = 8,
    parameter int N      = 32,
    parameter int PTR_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [PTR_W-1:0]    addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [N*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_rd
            assign rdata[g*DATA_W +: DATA_W] = mem[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_input_framer.sv
`default_nettype none
// ============================================================================
// Module   : fft_input_framer
// Purpose  : Collects serial DATA_W samples into N-sample frames. The frames
//            are ping-pong buffered: one bank fills while the other is held
//            for the FFT.
// Ports    : CLK_10 - clock, rising edge.
//            RST    - asynchronous active-low reset.
//            bus    - fft_input_framer_if.slave, which carries the sample
//                     handshake, flush, the frame handshake and frame_cnt.
// Config   : FFT_INPUT_BITREV_EN - when defined, sample k is written to slot
//            bitrev(k). This gives decimation-in-time order. When undefined,
//            sample k is written to slot k.
// Revision : 1.0 - initial release
// ============================================================================
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_IN_W,
    parameter int N      = FFT_N,
    parameter int PTR_W  = FFT_PTR_W,
    parameter int CNT_W  = 16
) (
    input  logic                CLK_10,
    input  logic                RST,
    fft_input_framer_if.slave   bus
);

    logic [1:0]          full;
    logic [1:0]          full_nxt;
    logic                wr_bank;
    logic                rd_bank;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    slot;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                last;
    logic                drain;
    logic [N*DATA_W-1:0] bank_rd [2];

    // RST gates s_ready, so the output stays low while the reset is applied.
    assign bus.s_ready     = RST && !full[wr_bank] && !bus.flush;
    assign accept          = bus.s_valid && bus.s_ready;
    assign last            = (wr_ptr == PTR_W'(N - 1));
    assign drain           = full[rd_bank] && bus.frame_ready;

    assign bus.frame_valid = full[rd_bank];
    assign bus.frame_data  = rd_bank ? bank_rd[1] : bank_rd[0];
    assign bus.frame_cnt   = cnt;

`ifdef FFT_INPUT_BITREV_EN
    always_comb begin
        slot = '0;
        for (int b = 0; b < PTR_W; b++) begin
            slot[b] = wr_ptr[PTR_W-1-b];
        end
    end
`else
    assign slot = wr_ptr;
`endif

    // When a frame completes and another drains in the same cycle, the two
    // banks involved are always different, so both flag updates apply.
    always_comb begin
        full_nxt = full;
        if (accept && last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (drain) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge CLK_10 or negedge RST) begin
        if (!RST) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_ptr  <= '0;
            cnt     <= '0;
        end else begin
            full <= full_nxt;
            if (bus.flush) begin
                wr_ptr <= '0;
            end else if (accept) begin
                if (last) begin
                    wr_bank <= ~wr_bank;
                    wr_ptr  <= '0;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (drain) begin
                rd_bank <= ~rd_bank;
                cnt     <= cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            fft_frame_bank #(
                .DATA_W (DATA_W),
                .N      (N),
                .PTR_W  (PTR_W)
            ) u_bank (
                .clk    (CLK_10),
                .rst_n  (RST),
                .we     (accept && (wr_bank == 1'(b))),
                .addr   (slot),
                .wdata  (bus.s_data),
                .rdata  (bank_rd[b])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_input_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_input_framer
// Purpose  : Scoreboard bench for fft_input_framer.
//            A second instance of the framer uses CNT_W=2 to exercise the
//            wrap of the frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_input_framer;

    localparam int DW = 8;
    localparam int NS = 32;
    localparam int FW = DW * NS;

    logic CLK_10 = 1'b0;
    logic RST    = 1'b0;

    always #5 CLK_10 = ~CLK_10;

    fft_input_framer_if #(.DATA_W(DW), .N(NS), .CNT_W(16)) bus  ();
    fft_input_framer_if #(.DATA_W(DW), .N(NS), .CNT_W(2))  bus2 ();

    assign bus2.flush       = bus.flush;
    assign bus2.s_data      = bus.s_data;
    assign bus2.s_valid     = bus.s_valid;
    assign bus2.frame_ready = bus.frame_ready;

    fft_input_framer #(.DATA_W(DW), .N(NS), .PTR_W(5), .CNT_W(16)) dut (
        .CLK_10 (CLK_10),
        .RST    (RST),
        .bus    (bus.slave)
    );

    fft_input_framer #(.DATA_W(DW), .N(NS), .PTR_W(5), .CNT_W(2)) dut2 (
        .CLK_10 (CLK_10),
        .RST    (RST),
        .bus    (bus2.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // The model keeps the samples of the frame being collected in partial.
    // Complete frames wait in pending (the expected-frame queue) until the
    // FFT consumes them.
    logic [DW-1:0] partial [$];
    logic [FW-1:0] pending [$];
    int            delivered = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int slot_of(input int k);
`ifdef FFT_INPUT_BITREV_EN
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((k >> b) & 1) != 0) r += (1 << (4 - b));
        end
        return r;
`else
        return k;
`endif
    endfunction

    // The monitor samples on the falling edge, midway between active edges.
    always @(negedge CLK_10) begin
        logic          exp_ready;
        logic [FW-1:0] f;
        if (!RST) begin
            chk("reset_s_ready",     FW'(bus.s_ready),     '0);
            chk("reset_frame_valid", FW'(bus.frame_valid), '0);
            chk("reset_frame_data",  bus.frame_data,       '0);
            chk("reset_frame_cnt",   FW'(bus.frame_cnt),   '0);
            chk("reset_frame_cnt2",  FW'(bus2.frame_cnt),  '0);
            partial.delete();
            pending.delete();
            delivered = 0;
        end else begin
            exp_ready = (pending.size() < 2) && !bus.flush;
            chk("s_ready",     FW'(bus.s_ready),     FW'(exp_ready));
            chk("frame_valid", FW'(bus.frame_valid), FW'(pending.size() > 0));
            chk("frame_cnt",   FW'(bus.frame_cnt),   FW'(delivered % 65536));
            chk("frame_cnt_w2", FW'(bus2.frame_cnt), FW'(delivered % 4));
            if (pending.size() > 0) begin
                chk("frame_data", bus.frame_data, pending[0]);
                if (bus.frame_ready) begin
                    void'(pending.pop_front());
                    delivered++;
                end
            end
            if (bus.flush) begin
                partial.delete();
            end else if (bus.s_valid && exp_ready) begin
                partial.push_back(bus.s_data);
                if (partial.size() == NS) begin
                    f = '0;
                    for (int k = 0; k < NS; k++) begin
                        f[slot_of(k)*DW +: DW] = partial[k];
                    end
                    pending.push_back(f);
                    partial.delete();
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic fr, input logic fl);
        @(posedge CLK_10);
        #1;
        bus.s_valid     = v;
        bus.s_data      = d;
        bus.frame_ready = fr;
        bus.flush       = fl;
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) drive(1'b0, '0, fr, 1'b0);
    endtask

    initial begin
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.frame_ready = 1'b0;
        bus.flush       = 1'b0;
        idle(3, 1'b0);
        #1 RST = 1'b1;

        // Assert the reset while a frame is part filled. 32 samples then make
        // exactly one frame.
        for (int i = 0; i < 10; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        @(posedge CLK_10); #1 RST = 1'b0;
        idle(2, 1'b0);
        #1 RST = 1'b1;
        for (int i = 0; i < 32; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Send a ramp with the FFT always ready.
        for (int i = 0; i < 32; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
        idle(4, 1'b1);

        // Hold frame_ready low and offer 70 samples. Then drain one frame.
        for (int i = 0; i < 70; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        drive(1'b1, DW'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        idle(40, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);

        // Flush a part-filled frame of 0xAA samples, then send a ramp.
        for (int i = 0; i < 7; i++) drive(1'b1, 8'hAA, 1'b1, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        for (int i = 0; i < 32; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Stream ten frames continuously.
        for (int i = 0; i < 320; i++) drive(1'b1, DW'($urandom), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Random traffic, with occasional flush pulses.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) == 0,
                  ($urandom % 60) == 0);
        end
        idle(5, 1'b1);

        @(negedge CLK_10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_input_framer.md
Name: fft_input_framer

Overview:
Upstream stage of the 32-point FFT pipeline. Collects a serial stream of 8-bit real samples into 32-sample frames and presents each frame in parallel to the FFT Top inputs x0..x31. Ping-pong double buffering lets one frame fill while the other is held for the FFT. Frame transfers use a valid/ready handshake; sample transfers use a valid/ready handshake.

Parameters:
DATA_W, 8, sample width; equals FFT Top input width.
N, 32, samples per frame (FFT size).
PTR_W, 5, write-pointer width, log2(N).
CNT_W, 16, width of frame counter.

Ports:
CLK_10  in  1  pipeline clock; all state on rising edge.
RST  in  1  asynchronous active-low reset.
flush  in  1  discard partially filled frame (sync, 1-cycle pulse).
s_data  in  DATA_W  serial sample.
s_valid  in  1  s_data valid.
s_ready  out  1  framer can accept a sample.
frame_data  out  N*DATA_W  frame; sample slot i at bits [i*DATA_W +: DATA_W], slot i drives FFT x_i.
frame_valid  out  1  frame_data holds an unconsumed full frame.
frame_ready  in  1  FFT consumes frame this cycle.
frame_cnt  out  CNT_W  frames delivered, wraps.

Behaviour:
- Reset (RST=0, async): both banks empty, all bank registers 0, wr_bank=0, rd_bank=0, wr_ptr=0, frame_cnt=0; outputs s_ready=0 during reset, then 1; frame_valid=0; frame_data=0.
- State: per bank a full flag; wr_bank, rd_bank (1 bit each); wr_ptr (PTR_W).
- s_ready = !full[wr_bank] && !flush (combinational from registers and flush).
- Sample accept (s_valid && s_ready): bank[wr_bank][slot(wr_ptr)] <= s_data; wr_ptr++.
- Frame complete: accept when wr_ptr==N-1. Set full[wr_bank], toggle wr_bank, wr_ptr <= 0.
- frame_valid = full[rd_bank]. frame_data = registers of bank rd_bank (mux, no extra register).
- Latency: last sample accepted at edge t gives frame_valid=1 in the cycle after t.
- frame_data is stable while frame_valid=1.
- Frame handshake (frame_valid && frame_ready): clear full[rd_bank], toggle rd_bank, frame_cnt++ (wraps 2^CNT_W-1 -> 0).
- frame_ready while frame_valid=0: ignored.
- Both banks full: s_ready=0 until a frame is drained. A sample offered in the same cycle as the drain is not accepted (s_ready was 0); it is accepted the next cycle.
- Simultaneous frame completion and frame drain: these always involve different banks, and both updates apply in the same edge.
- Back-to-back frames: a sustained stream with frame_ready=1 has no gaps in s_ready. Worst-case frame interval is N cycles.
- flush=1: wr_ptr <= 0. The partial frame is discarded (its data is left stale and later overwritten); full banks and rd side are untouched. Any sample presented that cycle is dropped (s_ready=0).
- Data is unsigned-agnostic: bits are passed through unchanged, with no width conversion.

Optional Feature:
Macro FFT_INPUT_BITREV_EN.
- Defined: slot(k) = bit-reverse of k over PTR_W bits, giving FFT decimation-in-time input ordering (sample 1 goes to slot 16).
- Undefined: slot(k) = k, natural order.
- Handshake and timing are identical in both builds.

Decomposition:
- Package fft_pkg: FFT_N=32, FFT_IN_W=8, FFT_PTR_W=5, FFT_OUT_W=32; function bitrev5; frame flat-bus width constant.
- Sub-module fft_frame_bank: N x DATA_W register array with async-low reset, one write port (we, addr, data), and flat N*DATA_W read bus. Instantiated twice.
- Top-level framer holds the pointers, full flags, muxes and counter.

Test Plan:
- Reset mid-frame: after 10 samples, pulse RST low. Expect frame_valid=0, frame_data=0, frame_cnt=0. Then 32 samples produce exactly 1 frame.
- Ramp 0..31 with s_valid=1 and frame_ready=1. Expect frame_valid 1 cycle after sample 31, slot i = i, and frame_cnt=1. With FFT_INPUT_BITREV_EN: slot 1=16, slot 3=24, slot 31=31.
- Backpressure: frame_ready=0, stream 70 samples. Expect s_ready=0 after sample 64 and frame_data = frame 0 held stable. Raise frame_ready for 1 cycle: frame 1 appears, s_ready returns 1 the next cycle.
- Flush: 7 samples (value 0xAA), flush pulse, then ramp 0..31. Expect the frame to equal the ramp, with no 0xAA in any slot.
- Continuous streaming of 10 frames with frame_ready=1. Expect no s_ready deassertion, 10 frame_valid pulses spaced 32 cycles apart, and frame_cnt=10.
- Counter wrap: with CNT_W=2, deliver 5 frames. Expect frame_cnt sequence 1,2,3,0,1.
